// File: rtl/ddr_init_wr_bridge_if.sv
// Generator-side instruction bus plus controller-side Avalon-MM write command bus.
// Pure wiring: no latency.
// Flow control: ddr_init_ins_gen_vld throttles the generator, avl_ready stalls the command.
interface ddr_init_wr_bridge_if #(
    parameter int BANDWIDTH = 512,
    parameter int ADDR_W    = 26
);
    logic                   ddr_init_ins_gen_vld;
    logic                   ddr_init_continue;
    logic                   ddr_init_ins_vld;
    logic [BANDWIDTH-1:0]   ddr_init_data;
    logic [ADDR_W-1:0]      ddr_init_addr;
    logic [6:0]             ddr_init_bl;
    logic                   ddr_init_rdreq;
    logic                   ddr_init_wrreq;
    logic                   ddr_init_finish;
    logic                   avl_ready;
    logic                   avl_write_req;
    logic [ADDR_W-1:0]      avl_addr;
    logic [BANDWIDTH-1:0]   avl_wdata;
    logic [6:0]             avl_size;
    logic [BANDWIDTH/8-1:0] avl_be;

    // Bridge view.
    modport slave (
        output ddr_init_ins_gen_vld, ddr_init_continue,
               avl_write_req, avl_addr, avl_wdata, avl_size, avl_be,
        input  ddr_init_ins_vld, ddr_init_data, ddr_init_addr, ddr_init_bl,
               ddr_init_rdreq, ddr_init_wrreq, ddr_init_finish, avl_ready
    );

    // Generator + controller view.
    modport master (
        input  ddr_init_ins_gen_vld, ddr_init_continue,
               avl_write_req, avl_addr, avl_wdata, avl_size, avl_be,
        output ddr_init_ins_vld, ddr_init_data, ddr_init_addr, ddr_init_bl,
               ddr_init_rdreq, ddr_init_wrreq, ddr_init_finish, avl_ready
    );
endinterface

// File: rtl/ddr_init_wr_bridge.sv
// Buffers DDR parameter-init write beats and issues them on the Avalon-MM write port.
// Latency: beat pushed at edge N is presented as avl_write_req after edge N+1; 1 beat/cycle sustained.
// Backpressure: avl_ready low holds the command; generator throttled once FIFO reaches DEPTH-SLACK.
module ddr_init_wr_bridge #(
    parameter int BANDWIDTH    = 512,
    parameter int ADDR_W       = 26,
    parameter int FIFO_DEPTH   = 16,
    parameter int SLACK        = 6,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 init_start_i,
    input  logic                 ddr_cal_done_i,
    ddr_init_wr_bridge_if.slave  bus,
    output logic [31:0]          wr_count_o,
    output logic                 init_done_o,
    output logic                 err_ovf_o
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WAIT_CAL, RUN, GAP, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [6:0]           bl;
        logic [ADDR_W-1:0]    addr;
        logic [BANDWIDTH-1:0] data;
    } entry_t;

    state_t              state_q, state_d;
    entry_t              mem_q [FIFO_DEPTH];
    entry_t              out_q;
    entry_t              push_ent;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    used_q;
    logic [IDLE_W-1:0]   idle_q, idle_d, idle_inc;
    logic [31:0]         wr_count_q;
    logic                req_q, gen_vld_q, gen_vld_d, err_ovf_q;
    logic                fifo_full, fifo_empty, push, pop, accept, ovf, activity;

    assign fifo_full  = (used_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (used_q == '0);
    assign accept     = req_q & bus.avl_ready;
    // Refill the output register whenever it is empty or being accepted this cycle.
    assign pop        = !fifo_empty && (!req_q || bus.avl_ready);
    // A full FIFO can still take a beat when one leaves in the same cycle.
    assign push       = bus.ddr_init_ins_vld && bus.ddr_init_wrreq && !bus.ddr_init_rdreq
                        && (!fifo_full || pop);
    assign ovf        = bus.ddr_init_ins_vld && fifo_full && !pop;
    assign activity   = bus.ddr_init_ins_vld || !fifo_empty || req_q;
    assign push_ent   = {bus.ddr_init_bl, bus.ddr_init_addr, bus.ddr_init_data};
    assign idle_inc   = (idle_q == IDLE_W'(IDLE_TIMEOUT)) ? idle_q : idle_q + IDLE_W'(1);

    // FIFO storage: data only, no reset needed since occupancy gates every read.
    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= push_ent;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            used_q    <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   used_q <= used_q + CNT_W'(1);
                2'b01:   used_q <= used_q - CNT_W'(1);
                default: used_q <= used_q;
            endcase
            if (ovf) err_ovf_q <= 1'b1;
        end
    end

    // Avalon command register: loads from the FIFO head, holds until accepted.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            req_q <= 1'b0;
            out_q <= '0;
        end else if (pop) begin
            req_q <= 1'b1;
            out_q <= mem_q[rd_ptr_q];
        end else if (accept) begin
            req_q <= 1'b0;
        end
    end

    // Saturating count of beats accepted by the controller.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                       wr_count_q <= '0;
        else if (accept && wr_count_q != '1) wr_count_q <= wr_count_q + 32'd1;
    end

    // Load sequencer state, idle counter and registered generator enable.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            idle_q    <= '0;
            gen_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            gen_vld_q <= gen_vld_d;
        end
    end

    // Next state: part boundaries are detected as a run of fully idle cycles in RUN.
    always_comb begin
        state_d   = state_q;
        idle_d    = '0;
        gen_vld_d = 1'b0;
        case (state_q)
            IDLE:     if (init_start_i) state_d = WAIT_CAL;
            WAIT_CAL: if (ddr_cal_done_i) state_d = RUN;
            RUN: begin
                idle_d = activity ? '0 : idle_inc;
                if (bus.ddr_init_finish) begin
                    state_d = DRAIN;
                end else begin
                    gen_vld_d = (used_q < CNT_W'(FIFO_DEPTH - SLACK));
                    if (idle_d == IDLE_W'(IDLE_TIMEOUT)) state_d = GAP;
                end
            end
            GAP: begin
                if (bus.ddr_init_finish) begin
                    state_d = DRAIN;
                end else begin
                    state_d   = RUN;
                    gen_vld_d = (used_q < CNT_W'(FIFO_DEPTH - SLACK));
                end
            end
            DRAIN:    if (fifo_empty && !req_q) state_d = DONE;
            DONE:     state_d = DONE;
            default:  state_d = IDLE;
        endcase
    end

    assign bus.ddr_init_ins_gen_vld = gen_vld_q;
    assign bus.ddr_init_continue    = (state_q == GAP) && !bus.ddr_init_finish;
    assign bus.avl_write_req        = req_q;
    assign bus.avl_addr             = out_q.addr;
    assign bus.avl_wdata            = out_q.data;
    assign bus.avl_size             = out_q.bl;
    assign bus.avl_be               = {(BANDWIDTH/8){req_q}};
    assign wr_count_o               = wr_count_q;
    assign init_done_o              = (state_q == DONE);
    assign err_ovf_o                = err_ovf_q;
endmodule

// File: tb/tb_ddr_init_wr_bridge.sv
// Directed bench for ddr_init_wr_bridge with a write scoreboard.
// Beats are pushed to the scoreboard when driven and checked as the controller accepts them.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_ddr_init_wr_bridge;
    localparam int BW      = 512;
    localparam int AW      = 26;
    localparam int DEPTH   = 16;
    localparam int SLACK   = 6;
    localparam int IDLE_TO = 8;

    typedef struct packed {
        logic [6:0]    bl;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          init_start = 1'b0;
    logic          cal_done = 1'b0;
    logic [31:0]   wr_count;
    logic          init_done, err_ovf;
    logic [BW/8-1:0] all_be = '1;

    exp_t sb_q[$];
    int   compared = 0, mismatched = 0;
    int   cyc = 0, cont_cnt = 0, cont_cyc = 0, last_acc_cyc = 0;
    int   pushed = 0, seq = 0, base = 0;
    bit   saw_low;

    ddr_init_wr_bridge_if #(.BANDWIDTH(BW), .ADDR_W(AW)) bus ();

    ddr_init_wr_bridge #(
        .BANDWIDTH(BW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .SLACK(SLACK), .IDLE_TIMEOUT(IDLE_TO)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .init_start_i(init_start),
        .ddr_cal_done_i(cal_done),
        .bus(bus),
        .wr_count_o(wr_count),
        .init_done_o(init_done),
        .err_ovf_o(err_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every accepted beat must match the oldest outstanding one.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (bus.ddr_init_continue === 1'b1) begin
                cont_cnt++;
                cont_cyc = cyc;
            end
            if (bus.avl_write_req === 1'b1 && bus.avl_ready === 1'b1) begin
                exp_t e;
                last_acc_cyc = cyc;
                chk("write_expected", BW'(sb_q.size() != 0), BW'(1));
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("avl_addr", BW'(bus.avl_addr), BW'(e.addr));
                    chk("avl_wdata", bus.avl_wdata, e.data);
                    chk("avl_size", BW'(bus.avl_size), BW'(e.bl));
                    chk("avl_be", BW'(bus.avl_be), BW'(all_be));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One generator beat; waits for gen_vld unless forced.
    task automatic send_one(input bit frc, input bit rd, input bit wr, input bit exp_push);
        int   t;
        exp_t e;
        t = 0;
        while (!frc && bus.ddr_init_ins_gen_vld !== 1'b1 && t < 500) begin
            tick();
            t++;
        end
        chk("gen_vld_wait", BW'(t < 500), BW'(1));
        e.addr = AW'(900000 + seq);
        e.bl   = 7'(1 + seq % 4);
        seq++;
        for (int w = 0; w < BW/32; w++) e.data[w*32 +: 32] = $urandom;
        bus.ddr_init_ins_vld = 1'b1;
        bus.ddr_init_rdreq   = rd;
        bus.ddr_init_wrreq   = wr;
        bus.ddr_init_addr    = e.addr;
        bus.ddr_init_data    = e.data;
        bus.ddr_init_bl      = e.bl;
        if (exp_push) begin
            sb_q.push_back(e);
            pushed++;
        end
        tick();
        bus.ddr_init_ins_vld = 1'b0;
        bus.ddr_init_rdreq   = 1'b0;
        bus.ddr_init_wrreq   = 1'b0;
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send_one(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        chk("drain_wait", BW'(t < 3000), BW'(1));
        repeat (2) tick();
    endtask

    task automatic wait_cont();
        int t;
        t = 0;
        while (bus.ddr_init_continue !== 1'b1 && t < 500) begin
            @(negedge sys_clk);
            t++;
        end
        chk("continue_wait", BW'(t < 500), BW'(1));
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, BW'(bus.avl_write_req), BW'(0));
        chk({tag, "_be"}, BW'(bus.avl_be), BW'(0));
        chk({tag, "_addr"}, BW'(bus.avl_addr), BW'(0));
        chk({tag, "_wdata"}, bus.avl_wdata, BW'(0));
        chk({tag, "_gen_vld"}, BW'(bus.ddr_init_ins_gen_vld), BW'(0));
        chk({tag, "_continue"}, BW'(bus.ddr_init_continue), BW'(0));
        chk({tag, "_wr_count"}, BW'(wr_count), BW'(0));
        chk({tag, "_init_done"}, BW'(init_done), BW'(0));
        chk({tag, "_err_ovf"}, BW'(err_ovf), BW'(0));
    endtask

    initial begin
        bus.ddr_init_ins_vld = 1'b0;
        bus.ddr_init_data    = '0;
        bus.ddr_init_addr    = '0;
        bus.ddr_init_bl      = '0;
        bus.ddr_init_rdreq   = 1'b0;
        bus.ddr_init_wrreq   = 1'b0;
        bus.ddr_init_finish  = 1'b0;
        bus.avl_ready        = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");

        // Start, then hold in WAIT_CAL until calibration completes.
        sys_rst_n = 1'b1;
        tick();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (5) tick();
        chk("gen_vld_wait_cal", BW'(bus.ddr_init_ins_gen_vld), BW'(0));
        cal_done = 1'b1;
        repeat (2) tick();
        chk("gen_vld_run", BW'(bus.ddr_init_ins_gen_vld), BW'(1));
        cal_done = 1'b0;

        // Test 1: dropped rdreq / no-wrreq beats, then 20 streamed beats.
        bus.avl_ready = 1'b1;
        send_one(1'b0, 1'b1, 1'b1, 1'b0);
        send_one(1'b0, 1'b0, 1'b0, 1'b0);
        send_n(20);
        wait_drain();
        chk("t1_wr_count", BW'(wr_count), BW'(20));

        // Test 2: controller stalls 50 cycles mid-stream.
        wait_cont();
        fork
            send_n(30);
            begin
                repeat (4) tick();
                bus.avl_ready = 1'b0;
                saw_low = 1'b0;
                repeat (50) begin
                    @(negedge sys_clk);
                    if (bus.ddr_init_ins_gen_vld === 1'b0) saw_low = 1'b1;
                end
                chk("t2_gen_vld_dropped", BW'(saw_low), BW'(1));
                chk("t2_gen_vld_end", BW'(bus.ddr_init_ins_gen_vld), BW'(0));
                chk("t2_outstanding", BW'(sb_q.size() >= DEPTH - SLACK && sb_q.size() <= DEPTH - SLACK + 2), BW'(1));
                chk("t2_err_ovf", BW'(err_ovf), BW'(0));
                tick();
                bus.avl_ready = 1'b1;
            end
        join
        wait_drain();
        chk("t2_wr_count", BW'(wr_count), BW'(pushed));

        // Test 3: a 5-beat part, then exactly one continue pulse after the idle timeout.
        wait_cont();
        base = cont_cnt;
        send_n(5);
        wait_cont();
        chk("t3_pulses", BW'(cont_cnt - base), BW'(1));
        chk("t3_pulse_delay", BW'(cont_cyc - last_acc_cyc), BW'(IDLE_TO + 1));

        // Test 4: finish with 3 beats queued.
        base = cont_cnt;
        bus.avl_ready = 1'b0;
        send_n(3);
        bus.ddr_init_finish = 1'b1;
        repeat (2) tick();
        chk("t4_gen_vld_off", BW'(bus.ddr_init_ins_gen_vld), BW'(0));
        repeat (20) tick();
        chk("t4_not_done_yet", BW'(init_done), BW'(0));
        chk("t4_req_held", BW'(bus.avl_write_req), BW'(1));
        bus.avl_ready = 1'b1;
        wait_drain();
        chk("t4_init_done", BW'(init_done), BW'(1));
        chk("t4_no_continue", BW'(cont_cnt - base), BW'(0));
        chk("t4_gen_vld_done", BW'(bus.ddr_init_ins_gen_vld), BW'(0));
        chk("t4_wr_count", BW'(wr_count), BW'(pushed));

        // Test 5: forced beats into a stalled bridge overflow it.
        sys_rst_n = 1'b0;
        tick();
        sb_q.delete();
        pushed = 0;
        bus.ddr_init_finish = 1'b0;
        chk("t5_reset_done", BW'(init_done), BW'(0));
        sys_rst_n = 1'b1;
        cal_done = 1'b1;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (2) tick();
        bus.avl_ready = 1'b0;
        for (int k = 0; k < 20; k++) send_one(1'b1, 1'b0, 1'b1, k < DEPTH + 1);
        chk("t5_err_ovf", BW'(err_ovf), BW'(1));
        chk("t5_gen_vld", BW'(bus.ddr_init_ins_gen_vld), BW'(0));
        tick();
        bus.avl_ready = 1'b1;
        wait_drain();
        chk("t5_wr_count", BW'(wr_count), BW'(DEPTH + 1));
        chk("t5_err_sticky", BW'(err_ovf), BW'(1));

        // Test 6: reset in the middle of a held burst.
        bus.avl_ready = 1'b0;
        send_n(4);
        chk("t6_req_before", BW'(bus.avl_write_req), BW'(1));
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        sb_q.delete();
        pushed = 0;
        tick();
        sys_rst_n = 1'b1;
        bus.avl_ready = 1'b1;
        repeat (5) tick();
        chk("t6_fifo_empty", BW'(bus.avl_write_req), BW'(0));
        chk("t6_idle_gen_vld", BW'(bus.ddr_init_ins_gen_vld), BW'(0));
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (3) tick();
        chk("t6_restart", BW'(bus.ddr_init_ins_gen_vld), BW'(1));
        chk("t6_wr_count", BW'(wr_count), BW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
